// File: rtl/fp_sqrt_controller_if.sv
// rtl/fp_sqrt_controller_if.sv - request/stage-control bundle between the sqrt sequencer and its neighbours
interface fp_sqrt_controller_if #(
   parameter int COUNT_WIDTH = 6
);
   logic                   start;
   logic                   isFloat;
   logic                   isSpecial;
   logic                   convIsDone;
   logic                   unpackEn;
   logic                   iterLoad;
   logic                   iterEn;
   logic                   convEn;
   logic                   packEn;
   logic                   specialSel;
   logic [COUNT_WIDTH-1:0] iterCount;
   logic                   floatLatched;
   logic                   busy;
   logic                   done;

   modport master (
      output start, isFloat, isSpecial, convIsDone,
      input  unpackEn, iterLoad, iterEn, convEn, packEn, specialSel,
      input  iterCount, floatLatched, busy, done
   );

   modport slave (
      input  start, isFloat, isSpecial, convIsDone,
      output unpackEn, iterLoad, iterEn, convEn, packEn, specialSel,
      output iterCount, floatLatched, busy, done
   );
endinterface

// File: rtl/fp_sqrt_controller.sv
// rtl/fp_sqrt_controller.sv - sequencing FSM for the floating-point square-root datapath
module fp_sqrt_controller #(
   parameter int                     COUNT_WIDTH       = 6,
   parameter logic [COUNT_WIDTH-1:0] SINGLE_ITERATIONS = COUNT_WIDTH'(24),
   parameter logic [COUNT_WIDTH-1:0] DOUBLE_ITERATIONS = COUNT_WIDTH'(53)
) (
   input logic                 clk,
   input logic                 rst,
   fp_sqrt_controller_if.slave bus
);
   localparam logic [COUNT_WIDTH-1:0] SINGLE_LAST = SINGLE_ITERATIONS - COUNT_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] DOUBLE_LAST = DOUBLE_ITERATIONS - COUNT_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_UNPACK,
      S_LOAD,
      S_ITER,
      S_CONVERT,
      S_PACK
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [COUNT_WIDTH-1:0] count_q;
   logic                   float_q;
   logic                   special_q;
   logic                   done_q;
   logic                   last_iter;
   logic                   unpack_en;
   logic                   iter_load;
   logic                   iter_en;
   logic                   conv_en;
   logic                   pack_en;

   assign last_iter = (count_q == (float_q ? SINGLE_LAST : DOUBLE_LAST));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      unpack_en = 1'b0;
      iter_load = 1'b0;
      iter_en   = 1'b0;
      conv_en   = 1'b0;
      pack_en   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_UNPACK;
         end
         S_UNPACK: begin
            unpack_en = 1'b1;
            state_d   = bus.isSpecial ? S_PACK : S_LOAD;
         end
         S_LOAD: begin
            iter_load = 1'b1;
            state_d   = S_ITER;
         end
         S_ITER: begin
            iter_en = 1'b1;
            if (last_iter) state_d = S_CONVERT;
         end
         S_CONVERT: begin
            conv_en = 1'b1;
            if (bus.convIsDone) state_d = S_PACK;
         end
         S_PACK: begin
            pack_en = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Counter parks on N-1 after the loop so the converter can still see the final index.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         float_q   <= 1'b0;
         special_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= (state_q == S_PACK);
         if (state_q == S_IDLE && bus.start) begin
            float_q <= bus.isFloat;
            count_q <= '0;
         end
         if (state_q == S_UNPACK) special_q <= bus.isSpecial;
         if (state_q == S_ITER && !last_iter) count_q <= count_q + COUNT_WIDTH'(1);
      end
   end

   assign bus.unpackEn     = unpack_en;
   assign bus.iterLoad     = iter_load;
   assign bus.iterEn       = iter_en;
   assign bus.convEn       = conv_en;
   assign bus.packEn       = pack_en;
   assign bus.specialSel   = special_q;
   assign bus.iterCount    = count_q;
   assign bus.floatLatched = float_q;
   assign bus.busy         = (state_q != S_IDLE);
   assign bus.done         = done_q;
endmodule

// File: doc/fp_sqrt_controller.md
# fp_sqrt_controller

Sequencing FSM for the floating-point square-root unit. It accepts a start request and selects single or double precision. It then steps the datapath through five stages: operand unpack, root-register load, the modified non-restoring iteration loop, binary-to-mantissa conversion and result packing. Stage enables are driven from one state register and an iteration counter. Completion is reported with a single-cycle done pulse. The block sits between the top-level request interface and the sqrt datapath units, and contains no arithmetic datapath of its own.

## Interface
Parameters:
- SINGLE_ITERATIONS, 6'd24, iteration count for single precision (24-bit root)
- DOUBLE_ITERATIONS, 6'd53, iteration count for double precision (53-bit root)
- COUNT_WIDTH, 6, iteration counter width; must hold DOUBLE_ITERATIONS

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- isFloat  input  1  1 = single precision, 0 = double; latched when start is accepted
- isSpecial  input  1  from the unpacker: operand is NaN, ±inf, ±0 or negative; sampled in UNPACK
- convIsDone  input  1  converter completion (isDone of the binary-to-mantissa stage)
- unpackEn  output  1  unpacker enable, high in UNPACK
- iterLoad  output  1  root/remainder register load, high in LOAD
- iterEn  output  1  one iteration step per cycle, high in ITER
- convEn  output  1  converter enable, high in CONVERT
- packEn  output  1  packer enable, high in PACK
- specialSel  output  1  packer selects the special-case result; latched in UNPACK, valid through PACK
- iterCount  output  COUNT_WIDTH  index of the current iteration, 0-based
- floatLatched  output  1  latched precision select
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle registered pulse after PACK

## Operation
- States: IDLE, UNPACK, LOAD, ITER, CONVERT, PACK. Encoding is free; only the observable behaviour below is fixed.
- IDLE → UNPACK on start. On that edge isFloat is latched into floatLatched and iterCount is cleared.
- UNPACK → PACK if isSpecial = 1. This bypasses LOAD, ITER and CONVERT; specialSel is set to 1.
- UNPACK → LOAD otherwise; specialSel is set to 0.
- LOAD → ITER unconditionally.
- ITER:
  - iterCount increments every cycle.
  - When iterCount = N−1, the next state is CONVERT.
  - N = SINGLE_ITERATIONS if floatLatched, else DOUBLE_ITERATIONS.
  - iterCount holds its final value (N−1) after leaving ITER, until the next accepted start.
- CONVERT → PACK when convIsDone = 1. The FSM stays in CONVERT while convIsDone = 0, with convEn held high. There is no timeout.
- PACK → IDLE unconditionally. done is registered high for exactly the next cycle, which is the first IDLE cycle.
- start while busy = 1 is ignored: no queuing, and floatLatched does not change.
- start in the IDLE cycle where done = 1 is accepted normally (back-to-back operation).
- isFloat and isSpecial outside their sampling states have no effect.
- Stage enables are mutually exclusive: at most one of unpackEn, iterLoad, iterEn, convEn, packEn is high in any cycle.

## Timing
- Reset: state = IDLE. All outputs are 0: iterCount = 0, floatLatched = 0, specialSel = 0, busy = 0, done = 0.
- Reset mid-operation (any state) returns to IDLE on the next edge with all outputs 0. A done pulse that was pending is suppressed.
- Cycle numbering: start is sampled high at edge 0.
  - UNPACK is cycle 1 and LOAD is cycle 2.
  - ITER occupies cycles 3 .. 2+N.
  - CONVERT starts at cycle 3+N and lasts 1+W cycles, where W = number of cycles convIsDone stays low.
  - PACK follows CONVERT; done is high in the cycle after PACK.
- Latency from start to done, with W = 0:
  - single: 29 cycles
  - double: 58 cycles
  - special-case bypass: 3 cycles (UNPACK cycle 1, PACK cycle 2, done cycle 3)
- busy rises in cycle 1 and falls in the done cycle.
- Outputs are Moore-type, decoded from registered state and counters. There is no combinational path from any input to any output.

## Test plan
- Reset, then single-precision request: rst for 2 cycles; start = 1, isFloat = 1, isSpecial = 0, convIsDone tied 1. Required: iterEn high for exactly 24 cycles, iterCount runs 0..23, done pulses once at cycle 29, busy is high for cycles 1–28.
- Double precision with converter stall: isFloat = 0; convIsDone held low for 3 cycles of CONVERT. Required: iterEn high for 53 cycles, convEn high for 4 cycles, done at cycle 61.
- Special-case bypass: isSpecial = 1 during UNPACK. Required: iterLoad, iterEn and convEn never assert; specialSel = 1 in PACK; done at cycle 3.
- Ignored start and precision hold: start pulses with isFloat = 0 during ITER of a single-precision op. Required: floatLatched stays 1, the iteration count stays 24, and no second operation begins.
- Back-to-back: start asserted in the done cycle with isFloat toggled. Required: UNPACK on the next cycle, and the new precision is latched.
- Reset mid-ITER: rst at iterCount = 10. Required: next cycle state is IDLE with all outputs 0, no done pulse, and a subsequent start behaves as after a clean reset.
